// File: rtl/axi_lite_pkg.sv
// Shared definitions for the data-side AXI4-Lite bridge: FSM encoding,
// response codes, protection default and byte-lane helpers.
package axi_lite_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WR_REQ  = 3'd3;
   localparam logic [2:0] ST_WR_RESP = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      RD_ADDR = ST_RD_ADDR,
      RD_DATA = ST_RD_DATA,
      WR_REQ  = ST_WR_REQ,
      WR_RESP = ST_WR_RESP,
      DONE    = ST_DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   // The core numbers byte 0 at the MSB lane; AXI numbers it at the LSB lane.
   function automatic logic [31:0] lane_swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] sel_reverse4(input logic [3:0] s);
      return {s[0], s[1], s[2], s[3]};
   endfunction

endpackage

// File: rtl/data_axi_lite_bridge.sv
// Turns single-beat memory-stage requests into AXI4-Lite master transactions,
// stalling the pipeline until each one retires.
module data_axi_lite_bridge
   import axi_lite_pkg::*;
#(
   parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF,
   parameter bit          LANE_SWAP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_write_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] mem_read_data_o,
   output logic        stall_req_o,
   output logic        bus_err_o,
   output logic [31:0] m_awaddr,
   output logic [2:0]  m_awprot,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] m_araddr,
   output logic [2:0]  m_arprot,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready
);

   state_t      state;
   state_t      state_next;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] read_data_q;
   logic        aw_done;
   logic        w_done;
   logic        discard;

   logic        start;
   logic        mid_txn;
   logic        drop;
   logic        aw_hs;
   logic        w_hs;
   logic        r_hs;
   logic        b_hs;
   logic [31:0] phys_addr;

   assign start     = (state == IDLE) && mem_ce_i && !flush_i;
   assign mid_txn   = (state == RD_ADDR) || (state == RD_DATA) ||
                      (state == WR_REQ)  || (state == WR_RESP);
   assign drop      = discard || flush_i;
   assign phys_addr = mem_addr_i & PHYS_MASK;

   assign m_arvalid = (state == RD_ADDR);
   assign m_rready  = (state == RD_DATA);
   assign m_awvalid = (state == WR_REQ) && !aw_done;
   assign m_wvalid  = (state == WR_REQ) && !w_done;
   assign m_bready  = (state == WR_RESP);

   assign aw_hs = m_awvalid && m_awready;
   assign w_hs  = m_wvalid && m_wready;
   assign r_hs  = m_rvalid && m_rready;
   assign b_hs  = m_bvalid && m_bready;

   assign m_araddr        = addr_q;
   assign m_awaddr        = addr_q;
   assign m_arprot        = PROT_DEFAULT;
   assign m_awprot        = PROT_DEFAULT;
   assign m_wdata         = wdata_q;
   assign m_wstrb         = wstrb_q;
   assign mem_read_data_o = read_data_q;

   // Errors are flagged in the handshake cycle only; the flow is unaffected.
   assign bus_err_o = !rst && ((r_hs && (m_rresp != RESP_OKAY)) ||
                               (b_hs && (m_bresp != RESP_OKAY)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A flushed transaction still runs to its AXI completion but skips DONE.
   always_comb begin
      state_next  = state;
      stall_req_o = 1'b0;
      case (state)
         IDLE: begin
            stall_req_o = mem_ce_i;
            if (start) begin
               state_next = mem_we_i ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            stall_req_o = 1'b1;
            if (m_arready) begin
               state_next = RD_DATA;
            end
         end
         RD_DATA: begin
            stall_req_o = 1'b1;
            if (m_rvalid) begin
               state_next = drop ? IDLE : DONE;
            end
         end
         WR_REQ: begin
            stall_req_o = 1'b1;
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
               state_next = WR_RESP;
            end
         end
         WR_RESP: begin
            stall_req_o = 1'b1;
            if (m_bvalid) begin
               state_next = drop ? IDLE : DONE;
            end
         end
         DONE: begin
            if (flush_i || !stall_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         stall_req_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         read_data_q <= 32'h0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         discard     <= 1'b0;
      end else begin
         if (start) begin
            addr_q  <= phys_addr & 32'hFFFF_FFFC;
            wdata_q <= LANE_SWAP ? lane_swap32(mem_write_data_i) : mem_write_data_i;
            wstrb_q <= LANE_SWAP ? sel_reverse4(mem_sel_i) : mem_sel_i;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) begin
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            w_done <= 1'b1;
         end
         if (r_hs) begin
            read_data_q <= LANE_SWAP ? lane_swap32(m_rdata) : m_rdata;
         end
         if (mid_txn && flush_i) begin
            discard <= 1'b1;
         end
         if (state_next == IDLE) begin
            discard <= 1'b0;
         end
      end
   end

endmodule
